parking_lot_occupancy: RTL and testbench
========================================

// Module: parking_lot_occupancy
// PURPOSE
//  Controller that sequences the lab's saturating occupancy counter from two gate sensors, a (outer) and b (inner).
//  Decodes the car-crossing order into single-cycle enter/exit events.
//  Applies each event as a bounded increment/decrement of the occupancy count.
//  Sits between the board's sensor inputs and the HEX/LED display logic.
// PARAMETERS
//  WIDTH     5   count width in bits
//  CAPACITY  25  maximum occupancy; count saturates here; must be <= 2**WIDTH-1
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-low reset
//  a          in   1      outer sensor, 1 = beam blocked
//  b          in   1      inner sensor, 1 = beam blocked
//  enter      out  1      one-cycle pulse: completed entry
//  exit       out  1      one-cycle pulse: completed exit
//  count      out  WIDTH  current occupancy, 0..CAPACITY
//  full       out  1      count == CAPACITY
//  empty      out  1      count == 0
//  seq_err    out  1      high while FSM is in ERR
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, count=0, enter=0, exit=0, full=0, empty=1, seq_err=0.
//  FSM states and the sensor pattern {a,b} each one tracks:
//   IDLE=00, E1=10, E2=11, E3=01 (entry path), X1=01, X2=11, X3=10 (exit path), ERR.
//  IDLE transitions: 10->E1, 01->X1, 00->IDLE, 11->ERR.
//  Entry path:
//   E1: 11->E2, 00->IDLE (abort, no event), 10 stay, 01->ERR.
//   E2: 01->E3, 10->E1 (car backs up), 11 stay, 00->ERR.
//   E3: 00->IDLE and fire entry, 11->E2, 01 stay, 10->ERR.
//  Exit path mirrors entry with a and b swapped; X3 with 00 ->IDLE and fires exit.
//  ERR: stays while {a,b}!=00; 00->IDLE. No event while in or leaving ERR.
//  Event latency: sample edge where E3/X3 sees 00 -> next cycle enter/exit=1 for exactly 1 cycle.
//   count is updated on that same edge.
//  Arithmetic and saturation:
//   count+1 only if count<CAPACITY; count-1 only if count>0.
//   Saturated events still pulse enter/exit; count holds.
//  full, empty and seq_err are registered, consistent with count/state every cycle.
//  Entry and exit are mutually exclusive by construction; never both in one cycle.
//  Reset mid-sequence: partial crossing is discarded and count returns to 0.
//   After release the FSM starts from IDLE, even if the sensors are not 00.
// CONFIGURATION
//  SENSOR_SYNC_EN defined:
//   a and b each pass a 2-flop synchronizer (async reset to 0) before the FSM.
//   Adds 2 cycles to all latencies above.
//  SENSOR_SYNC_EN undefined:
//   a and b feed the FSM directly; caller guarantees they are synchronous to clk.
// STRUCTURE
//  Package parking_pkg holds:
//   typedef enum logic [2:0] gate_state_t {IDLE,E1,E2,E3,X1,X2,X3,ERR}.
//   localparam defaults for WIDTH and CAPACITY.
//  Sub-module gate_sequence_fsm: a, b -> entry/exit pulses and seq_err.
//  The top level holds the synchronizers (under macro), the saturating count register and the full/empty flags.
// TESTING (timings given with SENSOR_SYNC_EN undefined)
//  1. Reset, then ab 00,10,11,01,00 one cycle each
//     -> enter=1 one cycle after 00 is sampled; count 0->1; empty 1->0.
//  2. From count=3, ab 00,01,11,10,00 -> exit pulse; count=2; enter never asserts.
//  3. Backing out: ab 10,11,10,00 -> no pulse, count unchanged, state returns to IDLE.
//  4. Saturation: 25 entries -> count=25, full=1; 26th entry -> enter pulses, count stays 25.
//     Exit at count=0 -> exit pulses, count stays 0.
//  5. Illegal pattern: IDLE with ab=11 -> seq_err=1 until ab=00, then seq_err=0.
//     A following valid entry counts normally.
//  6. Reset asserted mid-sequence while in E2 with count=7
//     -> count=0 and state=IDLE immediately (asynchronous, before the next edge).
//     After release, holding ab=11 does not produce an event.

Source files
------------

// File: rtl/parking_pkg.sv
// parking_pkg: gate FSM state encoding and default sizing for the occupancy counter
package parking_pkg;
  typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3, ERR} gate_state_t;
  localparam int WIDTH_DEF    = 5;
  localparam int CAPACITY_DEF = 25;
endpackage

// File: rtl/gate_sequence_fsm.sv
// gate_sequence_fsm: decodes outer/inner sensor order into enter/exit events and a sequence error flag
module gate_sequence_fsm
  import parking_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic enter_ev,
  output logic exit_ev,
  output logic enter,
  output logic exit,
  output logic seq_err
);
  gate_state_t state_q, state_d;
  logic enter_q, exit_q, seq_err_q;
  logic [1:0] ab;
  assign ab = {a, b};
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ab == 2'b10 ? E1 : ab == 2'b01 ? X1 : ab == 2'b11 ? ERR : IDLE;
      E1:      state_d = ab == 2'b11 ? E2 : ab == 2'b00 ? IDLE : ab == 2'b01 ? ERR : E1;
      E2:      state_d = ab == 2'b01 ? E3 : ab == 2'b10 ? E1 : ab == 2'b00 ? ERR : E2;
      E3:      state_d = ab == 2'b00 ? IDLE : ab == 2'b11 ? E2 : ab == 2'b10 ? ERR : E3;
      X1:      state_d = ab == 2'b11 ? X2 : ab == 2'b00 ? IDLE : ab == 2'b10 ? ERR : X1;
      X2:      state_d = ab == 2'b10 ? X3 : ab == 2'b01 ? X1 : ab == 2'b00 ? ERR : X2;
      X3:      state_d = ab == 2'b00 ? IDLE : ab == 2'b11 ? X2 : ab == 2'b01 ? ERR : X3;
      ERR:     state_d = ab == 2'b00 ? IDLE : ERR;
      default: state_d = IDLE;
    endcase
    enter_ev = state_q == E3 && ab == 2'b00;
    exit_ev  = state_q == X3 && ab == 2'b00;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      enter_q   <= 1'b0;
      exit_q    <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      enter_q   <= enter_ev;
      exit_q    <= exit_ev;
      seq_err_q <= state_d == ERR;
    end
  assign enter   = enter_q;
  assign exit    = exit_q;
  assign seq_err = seq_err_q;
endmodule

// File: rtl/parking_lot_occupancy.sv
// parking_lot_occupancy: saturating occupancy counter driven by gate sensors.
// SENSOR_SYNC_EN adds a 2-flop synchronizer on a and b (+2 cycles latency).
module parking_lot_occupancy
  import parking_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int CAPACITY = CAPACITY_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  output logic             enter,
  output logic             exit,
  output logic [WIDTH-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             seq_err
);
  localparam logic [WIDTH-1:0] CAP = WIDTH'(CAPACITY);
  logic a_s, b_s, enter_ev, exit_ev;
  logic [WIDTH-1:0] count_q, count_d;
  logic full_q, full_d, empty_q, empty_d;
`ifdef SENSOR_SYNC_EN
  logic [1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {a, b};
      sync2_q <= sync1_q;
    end
  assign {a_s, b_s} = sync2_q;
`else
  assign a_s = a;
  assign b_s = b;
`endif
  gate_sequence_fsm u_fsm (
    .clk     (clk),
    .reset   (reset),
    .a       (a_s),
    .b       (b_s),
    .enter_ev(enter_ev),
    .exit_ev (exit_ev),
    .enter   (enter),
    .exit    (exit),
    .seq_err (seq_err)
  );
  always_comb begin
    count_d = enter_ev && count_q < CAP ? count_q + WIDTH'(1) :
              exit_ev && count_q != '0  ? count_q - WIDTH'(1) : count_q;
    full_d  = count_d == CAP;
    empty_d = count_d == '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;
endmodule

// File: tb/tb_parking_lot_occupancy.sv
// tb_parking_lot_occupancy: scoreboard bench; expected events queued at stimulus, checked when pulses appear
module tb_parking_lot_occupancy;
  typedef struct packed {
    logic       en;
    logic       ex;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
  } exp_t;
  logic clk = 1'b0, reset = 1'b0, a = 1'b0, b = 1'b0;
  logic enter, exit, full, empty, seq_err;
  logic [4:0] count;
  int checks = 0, errors = 0;
  int exp_cnt = 0;
  exp_t q[$];
  parking_lot_occupancy dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .enter(enter), .exit(exit),
    .count(count), .full(full), .empty(empty), .seq_err(seq_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (reset && (enter || exit)) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event enter=%b exit=%b count=%0d", enter, exit, count);
      end else begin
        e = q.pop_front();
        if ({enter, exit, count, full, empty} !== e) begin
          errors++;
          $display("FAIL event got en=%b ex=%b cnt=%0d full=%b empty=%b want en=%b ex=%b cnt=%0d full=%b empty=%b",
                   enter, exit, count, full, empty, e.en, e.ex, e.cnt, e.full, e.empty);
        end
      end
    end
  task automatic drive(input logic [1:0] ab);
    {a, b} = ab;
    @(posedge clk);
    #1;
  endtask
  task automatic cross_in();
    exp_cnt = exp_cnt < 25 ? exp_cnt + 1 : exp_cnt;
    q.push_back('{1'b1, 1'b0, 5'(exp_cnt), exp_cnt == 25, exp_cnt == 0});
    drive(2'b10); drive(2'b11); drive(2'b01); drive(2'b00);
  endtask
  task automatic cross_out();
    exp_cnt = exp_cnt > 0 ? exp_cnt - 1 : exp_cnt;
    q.push_back('{1'b0, 1'b1, 5'(exp_cnt), exp_cnt == 25, exp_cnt == 0});
    drive(2'b01); drive(2'b11); drive(2'b10); drive(2'b00);
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s outstanding=%0d required=0", name, q.size());
      q.delete();
    end
  endtask
  task automatic check_state(input string name, input logic [4:0] c, input logic f, input logic em, input logic se);
    checks++;
    if ({count, full, empty, seq_err} !== {c, f, em, se}) begin
      errors++;
      $display("FAIL %s got cnt=%0d full=%b empty=%b seq_err=%b want cnt=%0d full=%b empty=%b seq_err=%b",
               name, count, full, empty, seq_err, c, f, em, se);
    end
  endtask
  task automatic test_reset();
    {a, b} = 2'b00;
    reset = 1'b0;
    #13;
    checks++;
    if ({enter, exit, count, full, empty, seq_err} !== {2'b00, 5'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset got en=%b ex=%b cnt=%0d full=%b empty=%b seq_err=%b", enter, exit, count, full, empty, seq_err);
    end
    q.delete();
    exp_cnt = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_entry();
    drive(2'b00);
    cross_in();
    drain("entry_pulse");
    drive(2'b00);
    checks++;
    if (enter !== 1'b0) begin
      errors++;
      $display("FAIL entry_single_cycle enter=%b required=0", enter);
    end
    check_state("after_entry", 5'd1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_exit();
    cross_in(); cross_in();
    drain("to_three");
    check_state("at_three", 5'd3, 1'b0, 1'b0, 1'b0);
    drive(2'b00);
    cross_out();
    drain("exit_pulse");
    check_state("after_exit", 5'd2, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_back_out();
    drive(2'b10); drive(2'b11); drive(2'b10); drive(2'b00); drive(2'b00);
    check_state("back_out", 5'd2, 1'b0, 1'b0, 1'b0);
    cross_in();
    drain("after_back_out");
    check_state("idle_after_back_out", 5'd3, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_saturation();
    while (exp_cnt < 25) cross_in();
    drain("fill");
    check_state("full", 5'd25, 1'b1, 1'b0, 1'b0);
    cross_in();
    drain("sat_entry");
    check_state("sat_hold", 5'd25, 1'b1, 1'b0, 1'b0);
    test_reset();
    cross_out();
    drain("exit_at_zero");
    check_state("zero_hold", 5'd0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic test_illegal();
    drive(2'b11);
    check_state("err_set", 5'd0, 1'b0, 1'b1, 1'b1);
    drive(2'b10); drive(2'b01);
    check_state("err_hold", 5'd0, 1'b0, 1'b1, 1'b1);
    drive(2'b00);
    check_state("err_clear", 5'd0, 1'b0, 1'b1, 1'b0);
    cross_in();
    drain("entry_after_err");
    check_state("count_after_err", 5'd1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_reset_mid();
    test_reset();
    repeat (7) cross_in();
    drain("to_seven");
    check_state("at_seven", 5'd7, 1'b0, 1'b0, 1'b0);
    drive(2'b10); drive(2'b11);
    #2 reset = 1'b0;
    #1;
    check_state("async_reset", 5'd0, 1'b0, 1'b1, 1'b0);
    exp_cnt = 0;
    #10 reset = 1'b1;
    repeat (2) drive(2'b11);
    check_state("held_11", 5'd0, 1'b0, 1'b1, 1'b1);
    drive(2'b00); drive(2'b00);
    check_state("after_release", 5'd0, 1'b0, 1'b1, 1'b0);
    drain("no_event_after_reset");
  endtask
  initial begin
    test_reset();
    test_entry();
    test_exit();
    test_back_out();
    test_saturation();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
